// File: rtl/jam_sched_if.sv
// jam_sched_if: permutation handshake, cost-table port and result outputs of jam_sched
interface jam_sched_if;
  logic perm_valid;
  logic [23:0] perm_job;
  logic perm_last;
  logic perm_ready;
  logic [2:0] W;
  logic [2:0] J;
  logic [7:0] Cost;
  logic [3:0] MatchCount;
  logic [9:0] MinCost;
  logic Valid;
  modport master(output perm_valid, perm_job, perm_last, Cost,
                 input perm_ready, W, J, MatchCount, MinCost, Valid);
  modport slave(input perm_valid, perm_job, perm_last, Cost,
                output perm_ready, W, J, MatchCount, MinCost, Valid);
endinterface

// File: rtl/jam_sched.sv
// jam_sched: scores 8x8 assignment permutations, tracks the minimum cost and how many permutations hit it
module jam_sched (
  input logic CLK,
  input logic RST,
  jam_sched_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] CMP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state;
  logic [23:0] job;
  logic last;
  logic [10:0] sum;
  logic [10:0] best;
  logic [2:0] k;
  logic [3:0] count;
  logic fresh;
  logic [10:0] eb;
  logic [3:0] ec;
  // a fresh run compares against an empty record while outputs still show the old one
  always_comb begin
    eb = fresh ? 11'h7ff : best;
    ec = fresh ? 4'd0 : count;
  end
  assign bus.perm_ready = state == IDLE;
  assign bus.W = state == FETCH ? k : 3'd0;
  assign bus.J = state == FETCH ? job[3*k +: 3] : 3'd0;
  assign bus.MatchCount = count;
  assign bus.MinCost = best[10] ? 10'h3ff : best[9:0];
  assign bus.Valid = state == DONE;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      job <= '0;
      last <= 1'b0;
      sum <= '0;
      k <= '0;
      best <= 11'h7ff;
      count <= '0;
      fresh <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.perm_valid) begin
          job <= bus.perm_job;
          last <= bus.perm_last;
          sum <= '0;
          k <= '0;
          state <= FETCH;
        end
        FETCH: begin
          sum <= sum + {3'd0, bus.Cost};
          k <= k + 3'd1;
          state <= k == 3'd7 ? CMP : FETCH;
        end
        CMP: begin
          best <= sum < eb ? sum : eb;
          count <= sum < eb ? 4'd1 : sum == eb ? (ec == 4'd15 ? ec : ec + 4'd1) : ec;
          fresh <= 1'b0;
          state <= last ? DONE : IDLE;
        end
        default: begin
          fresh <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jam_sched.sv
// tb_jam_sched: directed tables, corner sequences and randomized runs against a run-level cost model
module tb_jam_sched;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  jam_sched_if ifc();
  jam_sched dut (.CLK(CLK), .RST(RST), .bus(ifc.slave));
  always #5 CLK = ~CLK;
  logic [7:0] cost [8][8];
  assign ifc.Cost = cost[ifc.W][ifc.J];
  int total = 0;
  int passed = 0;
  typedef struct {logic [23:0] pj; bit pl; int mc; int mn;} vec_t;
  vec_t tv[3];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask

  function automatic logic [23:0] rot(input int s);
    logic [23:0] r = '0;
    for (int i = 0; i < 8; i++) r[3*i +: 3] = 3'((i + s) % 8);
    return r;
  endfunction

  function automatic logic [23:0] rev();
    logic [23:0] r = '0;
    for (int i = 0; i < 8; i++) r[3*i +: 3] = 3'(7 - i);
    return r;
  endfunction

  function automatic logic [23:0] shuffle();
    int p[8];
    int j, t;
    logic [23:0] r = '0;
    for (int i = 0; i < 8; i++) p[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < 8; i++) r[3*i +: 3] = 3'(p[i]);
    return r;
  endfunction

  function automatic int psum(input logic [23:0] pj);
    int s = 0;
    for (int i = 0; i < 8; i++) s += cost[i][pj[3*i +: 3]];
    return s;
  endfunction

  task automatic fill(input int mode);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        cost[w][j] = mode == 0 ? 8'd1 : mode == 1 ? 8'(j) : mode == 2 ? (w == 0 ? 8'(10 * j) : 8'd0) :
                     mode == 3 ? 8'd255 : mode == 4 ? 8'd2 : mode == 5 ? 8'($urandom_range(0, 255)) :
                     8'($urandom_range(0, 3));
  endtask

  // called at a negedge; returns at the negedge 10 cycles after acceptance
  task automatic send(input logic [23:0] pj, input bit pl, output int vc, output int mce);
    int n = 0;
    while (!ifc.perm_ready && n < 50) begin @(negedge CLK); n++; end
    chk("ready_timeout", int'(n < 50), 1);
    ifc.perm_valid = 1'b1; ifc.perm_job = pj; ifc.perm_last = pl;
    @(negedge CLK);
    ifc.perm_valid = 1'b0;
    mce = ifc.MatchCount;
    vc = 0;
    for (int c = 1; c <= 10; c++) begin
      if (ifc.Valid && vc == 0) vc = c;
      if (c < 10) @(negedge CLK);
    end
  endtask

  initial begin
    int vc, mce, len, mn, cnt, s, prev_mc, prev_mn, bad;
    logic [23:0] pj;
    ifc.perm_valid = 1'b0; ifc.perm_job = '0; ifc.perm_last = 1'b0;
    fill(0);
    @(negedge CLK);
    chk("rst_W", ifc.W, 0);
    chk("rst_J", ifc.J, 0);
    chk("rst_valid", ifc.Valid, 0);
    chk("rst_ready", ifc.perm_ready, 1);
    chk("rst_mc", ifc.MatchCount, 0);
    chk("rst_min", ifc.MinCost, 1023);
    RST = 1'b0;
    @(negedge CLK);

    send(rot(0), 1, vc, mce);
    chk("ones_vcyc", vc, 10);
    chk("ones_min", ifc.MinCost, 8);
    chk("ones_mc", ifc.MatchCount, 1);

    fill(1);
    send(rot(0), 0, vc, mce);
    chk("idx_novalid", vc, 0);
    send(rev(), 1, vc, mce);
    chk("idx_vcyc", vc, 10);
    chk("idx_min", ifc.MinCost, 28);
    chk("idx_mc", ifc.MatchCount, 2);

    fill(2);
    tv[0] = '{rot(4), 0, 1, 40};
    tv[1] = '{rot(4), 0, 2, 40};
    tv[2] = '{rot(3), 1, 1, 30};
    for (int i = 0; i < 3; i++) begin
      send(tv[i].pj, tv[i].pl, vc, mce);
      chk("tab_mc", ifc.MatchCount, tv[i].mc);
      chk("tab_min", ifc.MinCost, tv[i].mn);
      chk("tab_vcyc", vc, tv[i].pl ? 10 : 0);
    end

    fill(0);
    for (int i = 0; i < 17; i++) send(shuffle(), i == 16, vc, mce);
    chk("sat_mc", ifc.MatchCount, 15);
    chk("sat_min", ifc.MinCost, 8);
    send(rot(2), 1, vc, mce);
    chk("sat_hold", mce, 15);
    chk("sat_restart", ifc.MatchCount, 1);

    fill(3);
    send(shuffle(), 1, vc, mce);
    chk("max_min", ifc.MinCost, 1023);
    chk("max_mc", ifc.MatchCount, 1);

    fill(1);
    send(rot(0), 1, vc, mce);
    chk("done_ready", ifc.perm_ready, 0);
    ifc.perm_valid = 1'b1; ifc.perm_job = rot(5); ifc.perm_last = 1'b1;
    @(negedge CLK);
    chk("done_noacc_J", ifc.J, 0);
    chk("done_idle_ready", ifc.perm_ready, 1);
    @(negedge CLK);
    ifc.perm_valid = 1'b0;
    chk("acc_W", ifc.W, 0);
    chk("acc_J", ifc.J, 5);
    repeat (9) @(negedge CLK);
    chk("acc_valid", ifc.Valid, 1);
    chk("acc_min", ifc.MinCost, 28);
    @(negedge CLK);

    ifc.perm_valid = 1'b1; ifc.perm_job = rot(1); ifc.perm_last = 1'b1;
    @(negedge CLK);
    ifc.perm_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort_W", ifc.W, 4);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_rst_W", ifc.W, 0);
    chk("abort_rst_ready", ifc.perm_ready, 1);
    RST = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin @(negedge CLK); bad += int'(ifc.Valid); end
    chk("abort_novalid", bad, 0);
    chk("abort_mc", ifc.MatchCount, 0);
    chk("abort_min", ifc.MinCost, 1023);
    fill(4);
    send(rot(6), 1, vc, mce);
    chk("abort_new_vcyc", vc, 10);
    chk("abort_new_min", ifc.MinCost, 16);
    chk("abort_new_mc", ifc.MatchCount, 1);

    prev_mc = 1; prev_mn = 16;
    for (int r = 0; r < 8; r++) begin
      fill(r % 2 ? 6 : 5);
      len = $urandom_range(1, 6);
      mn = 1 << 30; cnt = 0;
      for (int i = 0; i < len; i++) begin
        pj = shuffle();
        s = psum(pj);
        if (s < mn) begin mn = s; cnt = 0; end
        if (s == mn) cnt++;
        send(pj, i == len - 1, vc, mce);
        if (i == 0) chk("rnd_hold_mc", mce, prev_mc);
      end
      prev_mc = cnt > 15 ? 15 : cnt;
      prev_mn = mn > 1023 ? 1023 : mn;
      chk("rnd_vcyc", vc, 10);
      chk("rnd_min", ifc.MinCost, prev_mn);
      chk("rnd_mc", ifc.MatchCount, prev_mc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
